// File: rtl/piso_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin PISO scheduler.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package piso_sched_pkg;

  // Upper bound on requester count that rr_pick can search.
  localparam int MAX_REQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic        found;
    logic [31:0] idx;
  } rr_res_t;

  // Bit counter width for a given word width (at least one bit).
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  // Counter width of the default 16-bit instance.
  localparam int CNT_W = cnt_width(16);

  // First set bit of valid, searching upward from last+1 and wrapping at num_req.
  function automatic rr_res_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int num_req,
                                      input int last);
    rr_res_t r;
    int      idx;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req && !r.found) begin
        idx = (last + k) % num_req;
        if (valid[idx[4:0]]) begin
          r.found = 1'b1;
          r.idx   = idx;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_rr_scheduler_if.sv
// Bundle of requester, PISO and framed serial signals around the scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; serial side has no stall.
// master = scheduler side, slave = requesters, PISO and serial consumer.
interface piso_rr_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SRC_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         piso_din;
  logic                          piso_din_en;
  logic                          piso_dout;
  logic                          ser_dout;
  logic                          ser_valid;
  logic                          ser_first;
  logic                          ser_last;
  logic [SRC_W-1:0]              ser_src;
  logic                          busy;

  modport master (
    input  req_valid, req_data, piso_dout,
    output req_ready, piso_din, piso_din_en,
           ser_dout, ser_valid, ser_first, ser_last, ser_src, busy
  );

  modport slave (
    output req_valid, req_data, piso_dout,
    input  req_ready, piso_din, piso_din_en,
           ser_dout, ser_valid, ser_first, ser_last, ser_src, busy
  );
endinterface

// File: rtl/piso_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after i_last_grant, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: i_enable low forces no grant; pointer update is left to the caller.
// Ports: i_req request vector, i_last_grant previous winner, i_enable,
//        o_grant one-hot, o_idx winner index, o_found any grant.
module rr_arbiter
  import piso_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_last_grant,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_found
);

  logic [MAX_REQ-1:0] w_req_ext;
  rr_res_t            w_pick;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = i_req;
    w_pick                 = rr_pick(w_req_ext, NUM_REQ, int'(i_last_grant));
  end

  assign o_found = i_enable && w_pick.found;
  assign o_idx   = SRC_W'(w_pick.idx);

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_found && (w_pick.idx == i)) o_grant[i] = 1'b1;
    end
  end

endmodule

// File: rtl/piso_rr_scheduler.sv
// Shares one PISO among NUM_REQ requesters, round-robin, and frames its serial output.
// Latency: word accepted in cycle T -> bit 0 at T+1, bit DATA_WIDTH-1 at T+DATA_WIDTH.
// Backpressure: req_ready only in a load window (idle or last bit); words stream back-to-back.
// Ports: clk, resetn (async active-low), bus (requesters, PISO din/din_en/dout, ser_* framing, busy).
module piso_rr_scheduler
  import piso_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                resetn,
  piso_rr_scheduler_if.master bus
);

  localparam int            CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic [SRC_W-1:0]   r_last_grant, w_last_grant_nxt;
  logic [SRC_W-1:0]   r_cur_src, w_cur_src_nxt;

  logic               w_load_win;
  logic               w_take;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [SRC_W-1:0]   w_gnt_idx;

  assign w_load_win = (r_state == IDLE) || (r_bit_cnt == LAST_BIT);

  // resetn gates the enable so req_ready stays low while reset is asserted,
  // even though the registers already sit in IDLE.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_arb (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .i_enable     (w_load_win && resetn),
    .o_grant      (w_gnt_oh),
    .o_idx        (w_gnt_idx),
    .o_found      (w_take)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_last_grant <= SRC_W'(NUM_REQ - 1);
      r_cur_src    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cur_src    <= w_cur_src_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_last_grant_nxt = r_last_grant;
    w_cur_src_nxt    = r_cur_src;
    if (w_take) begin
      // A grant in the last-bit cycle restarts the count with no bubble.
      w_state_nxt      = SHIFT;
      w_bit_cnt_nxt    = '0;
      w_last_grant_nxt = w_gnt_idx;
      w_cur_src_nxt    = w_gnt_idx;
    end else if (r_state == SHIFT) begin
      // Explicit compare keeps the count in range for non-power-of-two widths.
      if (r_bit_cnt == LAST_BIT) begin
        w_state_nxt   = IDLE;
        w_bit_cnt_nxt = '0;
      end else begin
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    bus.piso_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) bus.piso_din = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.req_ready   = w_gnt_oh;
  assign bus.piso_din_en = w_take;
  assign bus.ser_dout    = bus.piso_dout;
  assign bus.ser_valid   = (r_state == SHIFT);
  assign bus.ser_first   = (r_state == SHIFT) && (r_bit_cnt == '0);
  assign bus.ser_last    = (r_state == SHIFT) && (r_bit_cnt == LAST_BIT);
  assign bus.ser_src     = r_cur_src;
  assign bus.busy        = (r_state == SHIFT);

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Bench for piso_rr_scheduler with a behavioural PISO, directed sequences,
// an arbitration table and a queue-based reference model under random traffic.
module tb_piso_rr_scheduler;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int SW = 2;

  logic clk;
  logic resetn;

  piso_rr_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  piso_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PISO: synchronous reset, load on din_en, else shift right; dout is bit 0.
  logic [DW-1:0] piso_q;
  always @(posedge clk) begin
    if (!resetn)              piso_q <= '0;
    else if (bus.piso_din_en) piso_q <= bus.piso_din;
    else                      piso_q <= piso_q >> 1;
  end
  assign bus.piso_dout = piso_q[0];

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] words [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_data();
    bus.req_data = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic do_reset();
    resetn        = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
  } arb_vec_t;

  typedef struct {
    logic b;
    logic f;
    logic l;
    int   src;
  } sbit_t;

  typedef struct {
    logic [DW-1:0] w;
    int            src;
  } acc_t;

  sbit_t         mq [$];
  acc_t          acc_q [$];
  int            m_last;
  int            m_src;
  logic [DW-1:0] asm_w;
  logic [4:0]    asm_k;

  initial begin
    arb_vec_t      tbl [10];
    logic [DW-1:0] exp_w;
    logic [DW-1:0] exp_din;

    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int i = 0; i < NR; i++) words[i] = '0;

    // ---- reset state ----
    #2;
    chk("rst_ready",  32'(bus.req_ready),   32'h0);
    chk("rst_din_en", 32'(bus.piso_din_en), 32'h0);
    chk("rst_din",    32'(bus.piso_din),    32'h0);
    chk("rst_valid",  32'(bus.ser_valid),   32'h0);
    chk("rst_src",    32'(bus.ser_src),     32'h0);
    chk("rst_busy",   32'(bus.busy),        32'h0);

    // ---- single word A5C3 ----
    do_reset();
    words[0] = 16'hA5C3;
    set_data();
    bus.req_valid = 4'b0001;
    smp();
    chk("single_ready",  32'(bus.req_ready),   32'h1);
    chk("single_din_en", 32'(bus.piso_din_en), 32'h1);
    chk("single_din",    32'(bus.piso_din),    32'hA5C3);
    tick();
    bus.req_valid = '0;
    exp_w = 16'hA5C3;
    for (int k = 1; k <= DW; k++) begin
      smp();
      chk("single_dout",  32'(bus.ser_dout),  32'(exp_w[k-1]));
      chk("single_first", 32'(bus.ser_first), 32'(k == 1));
      chk("single_last",  32'(bus.ser_last),  32'(k == DW));
      chk("single_valid", 32'(bus.ser_valid), 32'h1);
      chk("single_src",   32'(bus.ser_src),   32'h0);
      tick();
    end
    smp();
    chk("single_idle_valid", 32'(bus.ser_valid), 32'h0);
    chk("single_idle_busy",  32'(bus.busy),      32'h0);
    tick();

    // ---- round-robin, all valid, zero-bubble stream ----
    do_reset();
    words[0] = 16'h0001; words[1] = 16'h0002; words[2] = 16'h0004; words[3] = 16'h0008;
    set_data();
    bus.req_valid = 4'b1111;
    for (int c = 0; c <= 5 * DW; c++) begin
      smp();
      chk("rr_ready", 32'(bus.req_ready),
          (c % DW == 0) ? (32'h1 << ((c / DW) % NR)) : 32'h0);
      if (c >= 1) begin
        chk("rr_valid", 32'(bus.ser_valid), 32'h1);
        chk("rr_first", 32'(bus.ser_first), 32'(c % DW == 1));
        chk("rr_last",  32'(bus.ser_last),  32'(c % DW == 0));
        chk("rr_src",   32'(bus.ser_src),   32'(((c - 1) / DW) % NR));
      end
      tick();
    end
    bus.req_valid = '0;

    // ---- arbitration table: one load window per record ----
    tbl[0] = '{4'b1010, 4'b0010};
    tbl[1] = '{4'b1010, 4'b1000};
    tbl[2] = '{4'b1010, 4'b0010};
    tbl[3] = '{4'b1010, 4'b1000};
    tbl[4] = '{4'b0000, 4'b0000};
    tbl[5] = '{4'b1111, 4'b0001};
    tbl[6] = '{4'b0101, 4'b0100};
    tbl[7] = '{4'b0101, 4'b0001};
    tbl[8] = '{4'b1001, 4'b1000};
    tbl[9] = '{4'b0110, 4'b0010};
    do_reset();
    for (int i = 0; i < NR; i++) words[i] = 16'h1111 * 16'(i + 1);
    set_data();
    for (int r = 0; r < 10; r++) begin
      bus.req_valid = tbl[r].valid;
      exp_din = '0;
      for (int i = 0; i < NR; i++) if (tbl[r].exp_ready[i]) exp_din = words[i];
      smp();
      chk("tbl_ready",  32'(bus.req_ready),   32'(tbl[r].exp_ready));
      chk("tbl_din_en", 32'(bus.piso_din_en), 32'(|tbl[r].exp_ready));
      chk("tbl_din",    32'(bus.piso_din),    32'(exp_din));
      tick();
      bus.req_valid = '0;
      repeat (DW) tick();
    end

    // ---- late arrival: no grant until the last bit ----
    do_reset();
    bus.req_valid = 4'b0001;
    smp();
    chk("late_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0100;
    for (int c = 1; c < DW; c++) begin
      smp();
      chk("late_no_grant", 32'(bus.req_ready), 32'h0);
      tick();
    end
    smp();
    chk("late_grant", 32'(bus.req_ready), 32'h4);
    chk("late_last",  32'(bus.ser_last),  32'h1);
    tick();
    bus.req_valid = '0;
    smp();
    chk("late_next_first", 32'(bus.ser_first), 32'h1);
    chk("late_next_src",   32'(bus.ser_src),   32'h2);
    tick();

    // ---- reset mid-word at bit 7 ----
    do_reset();
    words[2] = 16'h3C5A;
    set_data();
    bus.req_valid = 4'b0001;
    smp();
    chk("mid_grant0", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    repeat (7) tick();
    smp();
    chk("mid_bit7_valid", 32'(bus.ser_valid), 32'h1);
    bus.req_valid = 4'b0100;
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(bus.req_ready),   32'h0);
    chk("mid_rst_din_en", 32'(bus.piso_din_en), 32'h0);
    chk("mid_rst_din",    32'(bus.piso_din),    32'h0);
    chk("mid_rst_valid",  32'(bus.ser_valid),   32'h0);
    chk("mid_rst_first",  32'(bus.ser_first),   32'h0);
    chk("mid_rst_last",   32'(bus.ser_last),    32'h0);
    chk("mid_rst_src",    32'(bus.ser_src),     32'h0);
    chk("mid_rst_busy",   32'(bus.busy),        32'h0);
    chk("mid_rst_dout",   32'(bus.ser_dout),    32'(piso_q[0]));
    @(posedge clk);
    #1 resetn = 1'b1;
    smp();
    chk("mid_regrant",    32'(bus.req_ready),   32'h4);
    chk("mid_regrant_en", 32'(bus.piso_din_en), 32'h1);
    chk("mid_regrant_din", 32'(bus.piso_din),   32'h3C5A);
    tick();
    bus.req_valid = '0;
    smp();
    chk("mid_restart_first", 32'(bus.ser_first), 32'h1);
    chk("mid_restart_src",   32'(bus.ser_src),   32'h2);
    chk("mid_restart_b0",    32'(bus.ser_dout),  32'h0);
    tick();
    smp();
    chk("mid_restart_b1",    32'(bus.ser_dout),  32'h1);
    tick();

    // ---- random traffic vs queue-based reference model ----
    do_reset();
    mq.delete();
    acc_q.delete();
    m_last = NR - 1;
    m_src  = 0;
    asm_w  = '0;
    asm_k  = '0;
    for (int n = 0; n < 10000; n++) begin
      logic [NR-1:0] v;
      bit            found;
      int            g;
      logic [NR-1:0] e_ready;
      logic [DW-1:0] e_din;
      sbit_t         s;
      acc_t          a;

      case ($urandom_range(0, 3))
        0:       v = NR'($urandom);
        1:       v = NR'($urandom & $urandom);
        2:       v = NR'($urandom & $urandom & $urandom);
        default: v = NR'($urandom | $urandom);
      endcase
      for (int i = 0; i < NR; i++) words[i] = DW'($urandom);
      set_data();
      bus.req_valid = v;
      smp();

      // Load window: nothing queued, or only the final bit of a word left.
      found = 1'b0;
      g     = 0;
      if (mq.size() <= 1) begin
        for (int k = 1; k <= NR; k++) begin
          int idx;
          idx = (m_last + k) % NR;
          if (!found && v[idx]) begin
            found = 1'b1;
            g     = idx;
          end
        end
      end
      e_ready = found ? NR'(1 << g) : '0;
      e_din   = found ? words[g] : '0;
      chk("rnd_ready",  32'(bus.req_ready),   32'(e_ready));
      chk("rnd_din_en", 32'(bus.piso_din_en), 32'(found));
      chk("rnd_din",    32'(bus.piso_din),    32'(e_din));
      chk("rnd_valid",  32'(bus.ser_valid),   32'(mq.size() > 0));
      chk("rnd_busy",   32'(bus.busy),        32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rnd_dout",  32'(bus.ser_dout),  32'(mq[0].b));
        chk("rnd_first", 32'(bus.ser_first), 32'(mq[0].f));
        chk("rnd_last",  32'(bus.ser_last),  32'(mq[0].l));
        chk("rnd_src",   32'(bus.ser_src),   32'(mq[0].src));
      end else begin
        chk("rnd_idle_first", 32'(bus.ser_first), 32'h0);
        chk("rnd_idle_last",  32'(bus.ser_last),  32'h0);
        chk("rnd_idle_src",   32'(bus.ser_src),   32'(m_src));
      end

      // Reassemble words from the DUT's serial stream.
      if (bus.ser_valid) begin
        if (bus.ser_first) asm_k = '0;
        asm_w[asm_k[3:0]] = bus.ser_dout;
        asm_k = asm_k + 5'd1;
        if (bus.ser_last) begin
          if (acc_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rnd_word_unexpected at %0t: got word %0h with no accepted word pending",
                     $time, asm_w);
          end else begin
            a = acc_q.pop_front();
            chk("rnd_word",     32'(asm_w),       32'(a.w));
            chk("rnd_word_src", 32'(bus.ser_src), 32'(a.src));
            chk("rnd_word_len", 32'(asm_k),       32'(DW));
          end
        end
      end

      // Advance the model across the coming edge.
      if (mq.size() > 0) void'(mq.pop_front());
      if (found) begin
        for (int b = 0; b < DW; b++) begin
          s.b   = words[g][b];
          s.f   = (b == 0);
          s.l   = (b == DW - 1);
          s.src = g;
          mq.push_back(s);
        end
        a.w   = words[g];
        a.src = g;
        acc_q.push_back(a);
        m_last = g;
        m_src  = g;
      end
      tick();
    end
    bus.req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/piso_rr_scheduler.md
Name: piso_rr_scheduler

Overview:
- Shares one Parallel_In_Serial_Out_Shift_Reg instance between NUM_REQ word-producing requesters.
- Grants requesters in round-robin order and loads the winner's word into the shift register.
- Counts out DATA_WIDTH serial bits, LSB first, and frames them with first/last/source markers.
- Back-to-back words stream with no idle bit between them.

Parameters:
- DATA_WIDTH, 16: word width; must equal the PISO instance's DATA_WIDTH; legal range >= 2.
- NUM_REQ, 4: number of requesters; legal range >= 2.
- SRC_W, $clog2(NUM_REQ): width of the source index (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  bit i: requester i holds a word.
- req_data  in  NUM_REQ*DATA_WIDTH  word of requester i is req_data[i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; the word transfers when req_valid[i] and req_ready[i] are both high.
- piso_din  out  DATA_WIDTH  word to the PISO din port.
- piso_din_en  out  1  load strobe to the PISO din_en port.
- piso_dout  in  1  serial bit from the PISO dout port.
- ser_dout  out  1  framed serial bit; equals piso_dout.
- ser_valid  out  1  ser_dout carries a payload bit this cycle.
- ser_first  out  1  bit 0 of a word.
- ser_last  out  1  bit DATA_WIDTH-1 of a word.
- ser_src  out  SRC_W  index of the requester that owns the current bit.
- busy  out  1  equals ser_valid.

Behaviour:
- State machine states: IDLE and SHIFT. Registers: state, bit_cnt[$clog2(DATA_WIDTH)-1:0], last_grant[SRC_W-1:0], cur_src[SRC_W-1:0].
- Reset (async, resetn low) forces state=IDLE, bit_cnt=0, cur_src=0 and last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset values of outputs: req_ready=0, piso_din_en=0, piso_din=0, ser_valid=0, ser_first=0, ser_last=0, ser_src=0, busy=0, ser_dout=piso_dout.
- Load window: the cycle where state==IDLE, or state==SHIFT with bit_cnt==DATA_WIDTH-1.
- Grant:
  - In a load window with any req_valid set, grant g = first set req_valid index searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Same cycle, combinationally: req_ready[g]=1, piso_din=word g, piso_din_en=1.
  - On the next edge: last_grant<=g, cur_src<=g, bit_cnt<=0, state<=SHIFT.
- Outside a load window, or with no req_valid set: req_ready=0, piso_din_en=0, piso_din=0. req_ready never depends on req_data.
- SHIFT:
  - ser_valid=1, ser_src=cur_src, ser_first=(bit_cnt==0), ser_last=(bit_cnt==DATA_WIDTH-1).
  - bit_cnt increments each cycle.
  - At bit_cnt==DATA_WIDTH-1 with no grant: state<=IDLE, bit_cnt<=0.
  - At bit_cnt==DATA_WIDTH-1 with a grant: stay in SHIFT, bit_cnt<=0, giving a zero-bubble stream.
- IDLE: ser_valid=ser_first=ser_last=0; ser_src holds its last value.
- Latency: word accepted in cycle T -> bit 0 on ser_dout in T+1 -> bit DATA_WIDTH-1 in T+DATA_WIDTH.
- The scheduler never loads while the PISO is mid-word, which guarantees ser_dout is bit (cycle-T-1) of the accepted word.
- Requester deasserting req_valid before being granted: legal; it is simply skipped.
- Single requester active: it is granted back-to-back at every load window.
- Reset mid-word: the partial word is dropped, with no ser_last and no resume. The PISO's own synchronous reset is driven from the same resetn by the integrator.
- The reset release edge must be synchronous to clk.
- bit_cnt never exceeds DATA_WIDTH-1. When DATA_WIDTH is not a power of two, the counter compares explicitly rather than relying on wrap.

Decomposition:
- Package piso_sched_pkg:
  - state_t enum {IDLE, SHIFT};
  - function rr_pick(valid, last) returning grant index and a found flag;
  - localparam CNT_W for the bit counter width.
- One natural sub-module: rr_arbiter (parameter NUM_REQ; inputs req vector, last_grant, enable; outputs one-hot grant, grant index, found). It is reusable by other shared-datapath controllers.
- The top level holds the state machine, bit counter and mux and instantiates Parallel_In_Serial_Out_Shift_Reg only in the testbench.

Test Plan:
- Single word: DATA_WIDTH=16, req_valid=4'b0001, req_data[0]=16'hA5C3, held for one cycle.
  -> req_ready[0] and piso_din_en high in that cycle T.
  -> ser_dout in T+1..T+16 is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  -> ser_first at T+1, ser_last at T+16, ser_src=0, IDLE at T+17.
- Round-robin: all four valid continuously with words 16'h0001, 16'h0002, 16'h0004, 16'h0008.
  -> grants in order 0,1,2,3,0.
  -> ser_valid unbroken for 80 cycles.
  -> ser_last at T+16k; ser_first at the next cycle.
- Fairness skip: req_valid=4'b1010 after last_grant=1 -> next grant 3, then 1, then 3; requesters 0 and 2 never see ready.
- Late arrival: req 2 valid one cycle after the load window passes -> not granted until the current word's ser_last cycle; no grant mid-word.
- Reset mid-word: resetn low at bit 7 of a word.
  -> all outputs at reset values asynchronously.
  -> after release with req_valid=4'b0100, grant goes to requester 2 and the word restarts at bit 0 with ser_first.
- Reference model: scoreboard compares the reassembled ser_dout words and ser_src against the accepted req_data and grant index over 10k random valid patterns; zero mismatches.
